// File: rtl/ttc3_pkg.sv
// Shared types and default widths for the ttc3 key-slot datapath.
package ttc3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        LOADED,
        CLEAR
    } ks_state_e;

    localparam int TTC3_KEY_WIDTH  = 256;
    localparam int TTC3_INFO_WIDTH = 64;

endpackage

// File: rtl/ttc3_down_counter.sv
// Loadable down counter that saturates at zero; load wins over decrement.
module ttc3_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign value = count;
    assign zero  = (count == '0);

endmodule

// File: rtl/ttc3_key_slot.sv
// Single ephemeral key slot: drives one KDF derivation per request, serves the
// key for a bounded number of uses and cycles, then zeroizes.
module ttc3_key_slot
    import ttc3_pkg::*;
#(
    parameter int KEY_WIDTH       = TTC3_KEY_WIDTH,
    parameter int INFO_WIDTH      = TTC3_INFO_WIDTH,
    parameter int USE_WIDTH       = 4,
    parameter int LIFETIME_CYCLES = 1024,
    parameter int KDF_TIMEOUT     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INFO_WIDTH-1:0] req_info,
    input  logic [USE_WIDTH-1:0]  req_uses,
    output logic                  kdf_start,
    output logic [INFO_WIDTH-1:0] kdf_info,
    input  logic                  kdf_busy,
    input  logic                  kdf_done,
    input  logic [KEY_WIDTH-1:0]  derived_key,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic [KEY_WIDTH-1:0]  key_out,
    output logic [INFO_WIDTH-1:0] key_info,
    input  logic                  zeroize,
    output logic                  slot_loaded,
    output logic                  err_timeout
);

    localparam int WAIT_W = $clog2(KDF_TIMEOUT + 1);
    localparam int LIFE_W = $clog2(LIFETIME_CYCLES + 1);
    localparam logic [WAIT_W-1:0]    WAIT_LOAD = WAIT_W'(KDF_TIMEOUT);
    localparam logic [WAIT_W-1:0]    WAIT_ONE  = WAIT_W'(1);
    localparam logic [LIFE_W-1:0]    LIFE_LOAD = LIFE_W'(LIFETIME_CYCLES);
    localparam logic [LIFE_W-1:0]    LIFE_ONE  = LIFE_W'(1);
    localparam logic [USE_WIDTH-1:0] USE_ONE   = USE_WIDTH'(1);

    ks_state_e             state;
    logic [KEY_WIDTH-1:0]  key_q;
    logic [INFO_WIDTH-1:0] info_q;
    logic [USE_WIDTH-1:0]  uses_q;

    logic [WAIT_W-1:0] wait_val;
    logic              wait_zero;
    logic [LIFE_W-1:0] life_val;
    logic              life_zero;

    logic handshake;
    logic wait_expire;
    logic life_expire;
    logic last_use;
    logic go_clear;

    assign req_ready   = (state == IDLE) && !kdf_busy;
    assign kdf_start   = (state == START) && !zeroize;
    assign kdf_info    = ((state == START) || (state == WAIT)) ? info_q : '0;
    assign key_valid   = (state == LOADED) && !zeroize;
    assign key_out     = key_valid ? key_q : '0;
    assign key_info    = key_valid ? info_q : '0;
    assign slot_loaded = key_valid;

    // Expiry fires on the decrement that would reach zero, so WAIT lasts
    // exactly KDF_TIMEOUT cycles and LOADED exactly LIFETIME_CYCLES cycles.
    assign handshake   = key_valid && key_ready;
    assign wait_expire = (state == WAIT) && !zeroize && !kdf_done && (wait_val == WAIT_ONE);
    assign life_expire = (state == LOADED) && (life_val == LIFE_ONE);
    assign last_use    = handshake && (uses_q == USE_ONE);
    assign err_timeout = wait_expire;
    assign go_clear    = (zeroize && ((state == START) || (state == WAIT) || (state == LOADED)))
                         || wait_expire || life_expire || last_use;

    ttc3_down_counter #(
        .WIDTH(WAIT_W)
    ) u_wait_cnt (
        .clock     (clock),
        .reset     (reset),
        .load      ((state == START) || (state == CLEAR)),
        .load_value((state == START) ? WAIT_LOAD : '0),
        .dec       (state == WAIT),
        .value     (wait_val),
        .zero      (wait_zero)
    );

    ttc3_down_counter #(
        .WIDTH(LIFE_W)
    ) u_life_cnt (
        .clock     (clock),
        .reset     (reset),
        .load      (((state == WAIT) && kdf_done && !zeroize) || (state == CLEAR)),
        .load_value((state == WAIT) ? LIFE_LOAD : '0),
        .dec       (state == LOADED),
        .value     (life_val),
        .zero      (life_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            key_q  <= '0;
            info_q <= '0;
            uses_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        info_q <= req_info;
                        uses_q <= (req_uses == '0) ? USE_ONE : req_uses;
                        state  <= START;
                    end
                end
                START:  state <= WAIT;
                WAIT: begin
                    if (kdf_done) begin
                        key_q <= derived_key;
                        state <= LOADED;
                    end
                end
                LOADED: begin
                    if (handshake) begin
                        uses_q <= uses_q - USE_ONE;
                    end
                end
                CLEAR:   state <= IDLE;
                default: state <= IDLE;
            endcase
            // Any exit to CLEAR wipes the slot on the same edge, overriding a capture.
            if (go_clear) begin
                state  <= CLEAR;
                key_q  <= '0;
                info_q <= '0;
                uses_q <= '0;
            end
        end
    end

    a_key_zero_when_idle: assert property (@(posedge clock) disable iff (reset)
        ((state == IDLE) || (state == CLEAR)) |-> (key_q == '0));
    a_key_out_gated: assert property (@(posedge clock) disable iff (reset)
        !key_valid |-> (key_out == '0));
    a_start_one_cycle: assert property (@(posedge clock) disable iff (reset)
        kdf_start |=> !kdf_start);
    a_wait_cnt_live: assert property (@(posedge clock) disable iff (reset)
        (state == WAIT) |-> !wait_zero);
    a_life_cnt_live: assert property (@(posedge clock) disable iff (reset)
        (state == LOADED) |-> !life_zero);

endmodule

// File: tb/tb_ttc3_key_slot.sv
// Bench for ttc3_key_slot with a behavioural KDF stub and a key scoreboard.
module tb_ttc3_key_slot;

    localparam int KW = 256;
    localparam int IW = 64;
    localparam int UW = 4;
    localparam int LT = 8;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_info;
    logic [UW-1:0] req_uses;
    logic          kdf_start;
    logic [IW-1:0] kdf_info;
    logic          kdf_busy = 1'b0;
    logic          kdf_done = 1'b0;
    logic [KW-1:0] derived_key = '0;
    logic          key_valid;
    logic          key_ready;
    logic [KW-1:0] key_out;
    logic [IW-1:0] key_info;
    logic          zeroize;
    logic          slot_loaded;
    logic          err_timeout;

    ttc3_key_slot #(
        .KEY_WIDTH      (KW),
        .INFO_WIDTH     (IW),
        .USE_WIDTH      (UW),
        .LIFETIME_CYCLES(LT),
        .KDF_TIMEOUT    (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_info   (req_info),
        .req_uses   (req_uses),
        .kdf_start  (kdf_start),
        .kdf_info   (kdf_info),
        .kdf_busy   (kdf_busy),
        .kdf_done   (kdf_done),
        .derived_key(derived_key),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_out    (key_out),
        .key_info   (key_info),
        .zeroize    (zeroize),
        .slot_loaded(slot_loaded),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [KW-1:0] key;
        logic [IW-1:0] info;
    } sb_t;

    typedef struct {
        logic [IW-1:0] info;
        logic [UW-1:0] uses;
        int            delay;
        int            exp_hs;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[6];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_count = 0;
    int err_count = 0;
    int kv_count = 0;
    int hs_count = 0;
    int viol = 0;
    int start_cyc = 0;
    int err_cyc = 0;

    bit            stub_en = 1'b1;
    int            stub_delay = 10;
    int            busy_cnt = 0;
    logic [IW-1:0] stub_info = '0;

    function automatic logic [KW-1:0] kdf_model(input logic [IW-1:0] i);
        return {i ^ 64'h0123456789ABCDEF, ~i, {i[31:0], i[63:32]}, i + 64'h9E3779B97F4A7C15};
    endfunction

    task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // KDF stub: done pulses stub_delay cycles after the start pulse.
    always @(negedge clock) begin
        kdf_done    = 1'b0;
        derived_key = '0;
        if (reset) begin
            busy_cnt = 0;
            kdf_busy = 1'b0;
        end else if (kdf_start && stub_en) begin
            busy_cnt  = stub_delay;
            stub_info = kdf_info;
            kdf_busy  = 1'b1;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                kdf_busy    = 1'b0;
                kdf_done    = 1'b1;
                derived_key = kdf_model(stub_info);
            end
        end
    end

    always @(negedge clock) begin
        #1;
        if (!reset) begin
            if (kdf_start) begin
                start_count++;
                start_cyc = cyc;
            end
            if (err_timeout) begin
                err_count++;
                err_cyc = cyc;
            end
            if (key_valid) kv_count++;
            if (!key_valid && ((key_out != '0) || (key_info != '0))) viol++;
            if (slot_loaded !== key_valid) viol++;
            if (key_valid && key_ready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_key actual=%0h required=none", key_out);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_key", key_out, e.key);
                    chk("sb_info", key_info, e.info);
                end
            end
        end
    end

    task automatic expect_keys(input logic [IW-1:0] info, input int n);
        for (int k = 0; k < n; k++) sb.push_back('{key: kdf_model(info), info: info});
    endtask

    task automatic request(input logic [IW-1:0] info, input logic [UW-1:0] uses);
        int n = 0;
        @(negedge clock);
        #1;
        while (!req_ready && n < 100) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_info  = info;
        req_uses  = uses;
        @(negedge clock);
        req_valid = 1'b0;
        req_info  = '0;
        req_uses  = '0;
        #1;
        chk("kdf_start_latency", kdf_start, 1);
        chk("kdf_info_fwd", kdf_info, info);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!(req_ready && !key_valid) && n < limit);
        chk(name, req_ready, 1);
    endtask

    task automatic wait_loaded(input int limit, input string name);
        int n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
        end while (!key_valid && n < limit);
        chk(name, key_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0, st0, er0, kv0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_info  = '0;
        req_uses  = '0;
        key_ready = 1'b0;
        zeroize   = 1'b0;

        vecs[0] = '{64'h0000_0000_0000_0001, 4'd0, 3, 1};
        vecs[1] = '{64'hDEAD_BEEF_CAFE_F00D, 4'd1, 12, 1};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 4'd5, 1, 5};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 16, 8};
        vecs[4] = '{64'h5A5A_5A5A_A5A5_A5A5, 4'd8, 7, 8};
        vecs[5] = '{64'h0000_0000_0000_0000, 4'd3, 2, 3};

        repeat (3) @(negedge clock);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_kdf_start", kdf_start, 0);
        chk("rst_kdf_info", kdf_info, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_out", key_out, 0);
        chk("rst_key_info", key_info, 0);
        chk("rst_slot_loaded", slot_loaded, 0);
        chk("rst_err_timeout", err_timeout, 0);
        @(negedge clock);
        reset = 1'b0;

        // Two-use key, consumer always ready.
        key_ready  = 1'b1;
        stub_delay = 10;
        hs0 = hs_count;
        st0 = start_count;
        expect_keys(64'h4145532D4B4559, 2);
        request(64'h4145532D4B4559, 4'd2);
        wait_idle(100, "t1_idle");
        chk("t1_handshakes", hs_count - hs0, 2);
        chk("t1_starts", start_count - st0, 1);
        chk("t1_sb_empty", sb.size(), 0);

        for (int i = 0; i < 6; i++) begin
            stub_delay = vecs[i].delay;
            key_ready  = 1'b1;
            hs0 = hs_count;
            er0 = err_count;
            expect_keys(vecs[i].info, vecs[i].exp_hs);
            request(vecs[i].info, vecs[i].uses);
            wait_idle(100, $sformatf("vec%0d_idle", i));
            chk($sformatf("vec%0d_handshakes", i), hs_count - hs0, vecs[i].exp_hs);
            chk($sformatf("vec%0d_no_timeout", i), err_count - er0, 0);
            chk($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
        end

        // Lifetime expiry with no consumer.
        key_ready  = 1'b0;
        stub_delay = 4;
        kv0 = kv_count;
        hs0 = hs_count;
        request(64'h1111_2222_3333_4444, 4'd3);
        wait_idle(100, "t3_idle");
        chk("t3_valid_cycles", kv_count - kv0, LT);
        chk("t3_handshakes", hs_count - hs0, 0);

        // Zeroize while loaded.
        request(64'h7777_0000_7777_0000, 4'd2);
        wait_loaded(40, "zl_loaded");
        @(negedge clock);
        zeroize = 1'b1;
        #1;
        chk("zl_key_valid", key_valid, 0);
        chk("zl_key_out", key_out, 0);
        @(negedge clock);
        zeroize = 1'b0;
        #1;
        chk("zl_clear_not_ready", req_ready, 0);
        wait_idle(20, "zl_idle");

        // KDF never answers.
        stub_en = 1'b0;
        er0 = err_count;
        kv0 = kv_count;
        request(64'h0BAD_0BAD_0BAD_0BAD, 4'd1);
        wait_idle(100, "t4_ready_returns");
        chk("t4_err_pulses", err_count - er0, 1);
        chk("t4_err_delay", err_cyc - start_cyc, TO);
        chk("t4_no_key", kv_count - kv0, 0);
        stub_en = 1'b1;

        // Zeroize in WAIT, done arrives after the slot is cleared.
        stub_delay = 6;
        kv0 = kv_count;
        er0 = err_count;
        request(64'hFEED_FACE_FEED_FACE, 4'd2);
        repeat (4) @(negedge clock);
        zeroize = 1'b1;
        @(negedge clock);
        zeroize = 1'b0;
        repeat (6) @(negedge clock);
        wait_idle(50, "t5_idle");
        chk("t5_no_key", kv_count - kv0, 0);
        chk("t5_no_timeout", err_count - er0, 0);
        chk("t5_key_out", key_out, 0);

        // Reset during a handshake beat, then a fresh request.
        key_ready  = 1'b0;
        stub_delay = 5;
        request(64'hABCD_0123_ABCD_0123, 4'd3);
        wait_loaded(40, "t6_loaded");
        @(negedge clock);
        key_ready = 1'b1;
        expect_keys(64'hABCD_0123_ABCD_0123, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_key_valid", key_valid, 0);
        chk("t6_key_out", key_out, 0);
        chk("t6_key_info", key_info, 0);
        chk("t6_req_ready", req_ready, 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        hs0 = hs_count;
        expect_keys(64'h0F0F_F0F0_0F0F_F0F0, 1);
        request(64'h0F0F_F0F0_0F0F_F0F0, 4'd0);
        wait_idle(100, "t6_idle");
        chk("t6_handshakes", hs_count - hs0, 1);

        chk("final_gating_violations", viol, 0);
        chk("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
